// File: rtl/dm_wait_responder.sv
// Data-memory responder: word SRAM behind a request/stall handshake with a fixed
// number of wait states, plus a debug load/peek port and access counters.
module dm_wait_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       DM_address,
    input  logic [DATA_W-1:0] DM_in,
    input  logic              DM_enable,
    input  logic              DM_write,
    output logic [DATA_W-1:0] DM_out,
    output logic              stall,
    output logic              oob_err,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [31:0]         lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                lat_write;

    logic [31:0]         cur_addr;
    logic [DATA_W-1:0]   cur_data;
    logic                cur_write;
    logic [ADDR_W-1:0]   cur_idx;
    logic                cur_oob;
    logic                complete;
    logic                cpu_wr;
    logic                unused_lsbs;

    // Zero-latency accesses complete from the live request; otherwise from the latched copy.
    always_comb begin
        cur_addr  = lat_addr;
        cur_data  = lat_data;
        cur_write = lat_write;
        complete  = 1'b0;
        if (LATENCY == 0) begin
            cur_addr  = DM_address;
            cur_data  = DM_in;
            cur_write = DM_write;
            complete  = !rst && DM_enable;
        end else begin
            complete  = !rst && (state == S_WAIT) && (cnt == 4'd0);
        end
    end

    assign cur_idx     = cur_addr[ADDR_W+1:2];
    assign cur_oob     = |cur_addr[31:ADDR_W+2];
    assign unused_lsbs = ^cur_addr[1:0];
    assign cpu_wr      = complete && cur_write && !cur_oob;

    assign stall   = !rst && (((state == S_IDLE) && DM_enable && (LATENCY != 0)) ||
                              ((state == S_WAIT) && (cnt != 4'd0)));
    assign DM_out  = (complete && !cur_write && !cur_oob) ? mem[cur_idx] : '0;
    assign oob_err = complete && cur_oob;
    assign dbg_rdata = mem[dbg_addr];

    // A completing CPU write takes priority over a debug write in the same cycle.
    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            mem[cur_idx] <= cur_data;
        end else if (dbg_we) begin
            mem[dbg_addr] <= dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && DM_enable) begin
            lat_addr  <= DM_address;
            lat_data  <= DM_in;
            lat_write <= DM_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else begin
            if (complete && !cur_oob) begin
                if (cur_write) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (DM_enable && (LATENCY != 0)) begin
                        cnt   <= LAT_M1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_wait_responder.sv
// Bench for dm_wait_responder: a LATENCY=2 and a LATENCY=0 instance driven by a
// directed vector table, hand-written reset/collision sequences and random traffic.
module tb_dm_wait_responder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]       addr_s      [2];
    logic [DATA_W-1:0] din_s       [2];
    logic              en_s        [2];
    logic              wr_s        [2];
    logic [DATA_W-1:0] dout_s      [2];
    logic              stall_s     [2];
    logic              oob_s       [2];
    logic              dbg_we_s    [2];
    logic [ADDR_W-1:0] dbg_addr_s  [2];
    logic [DATA_W-1:0] dbg_wdata_s [2];
    logic [DATA_W-1:0] dbg_rdata_s [2];
    logic [31:0]       rd_cnt_s    [2];
    logic [31:0]       wr_cnt_s    [2];

    dm_wait_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .DM_address(addr_s[0]), .DM_in(din_s[0]), .DM_enable(en_s[0]), .DM_write(wr_s[0]),
        .DM_out(dout_s[0]), .stall(stall_s[0]), .oob_err(oob_s[0]),
        .dbg_we(dbg_we_s[0]), .dbg_addr(dbg_addr_s[0]), .dbg_wdata(dbg_wdata_s[0]),
        .dbg_rdata(dbg_rdata_s[0]), .rd_count(rd_cnt_s[0]), .wr_count(wr_cnt_s[0])
    );

    dm_wait_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst),
        .DM_address(addr_s[1]), .DM_in(din_s[1]), .DM_enable(en_s[1]), .DM_write(wr_s[1]),
        .DM_out(dout_s[1]), .stall(stall_s[1]), .oob_err(oob_s[1]),
        .dbg_we(dbg_we_s[1]), .dbg_addr(dbg_addr_s[1]), .dbg_wdata(dbg_wdata_s[1]),
        .dbg_rdata(dbg_rdata_s[1]), .rd_count(rd_cnt_s[1]), .wr_count(wr_cnt_s[1])
    );

    // Reference model: array contents and in-range access counts per instance.
    logic [31:0] mdl_mem [2][1024];
    int unsigned mdl_rd  [2];
    int unsigned mdl_wr  [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;
        logic [31:0] exp_out;
        bit          exp_oob;
    } vec_t;

    vec_t vecs [11];

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a[31:12] == 20'd0);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i);
        en_s[i]     = 1'b0;
        dbg_we_s[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("idle_stall%0d", i), stall_s[i], 0);
        chk($sformatf("idle_dout%0d", i), dout_s[i], 0);
        chk($sformatf("idle_oob%0d", i), oob_s[i], 0);
        step();
    endtask

    task automatic dbg_write(input int i, input logic [9:0] idx, input logic [31:0] d);
        en_s[i]        = 1'b0;
        dbg_we_s[i]    = 1'b1;
        dbg_addr_s[i]  = idx;
        dbg_wdata_s[i] = d;
        step();
        dbg_we_s[i]    = 1'b0;
        mdl_mem[i][idx] = d;
    endtask

    task automatic peek(input int i, input logic [9:0] idx, input logic [31:0] exp, input string name);
        dbg_addr_s[i] = idx;
        #1;
        chk(name, dbg_rdata_s[i], exp);
    endtask

    task automatic check_counts(input int i);
        chk($sformatf("rd_count%0d", i), rd_cnt_s[i], mdl_rd[i]);
        chk($sformatf("wr_count%0d", i), wr_cnt_s[i], mdl_wr[i]);
    endtask

    // One CPU access: stall must be high for exactly LATENCY cycles, then the completion cycle.
    task automatic access(input int i, input logic [31:0] a, input logic [31:0] d, input bit w,
                          input logic [31:0] exp_out, input bit exp_oob);
        int lat = lat_of(i);
        en_s[i]     = 1'b1;
        addr_s[i]   = a;
        din_s[i]    = d;
        wr_s[i]     = w;
        dbg_we_s[i] = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_c%0d", i, k), stall_s[i], (k < lat) ? 1 : 0);
            if (k == lat) begin
                chk($sformatf("dout%0d@%0h", i, a), dout_s[i], exp_out);
                chk($sformatf("oob%0d@%0h", i, a), oob_s[i], exp_oob);
            end else begin
                chk($sformatf("dout_early%0d", i), dout_s[i], 0);
                chk($sformatf("oob_early%0d", i), oob_s[i], 0);
            end
            step();
        end
        en_s[i] = 1'b0;
        if (in_range(a)) begin
            if (w) begin
                mdl_mem[i][a[11:2]] = d;
                mdl_wr[i]++;
            end else begin
                mdl_rd[i]++;
            end
        end
        check_counts(i);
    endtask

    task automatic rand_phase(input int i, input int n);
        logic [31:0] a, d, exp_out;
        logic [19:0] upper;
        logic [3:0]  idx;
        bit          w, oob;
        for (int j = 0; j < 16; j++) dbg_write(i, 10'(j), $urandom);
        for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 9))
                0: idle(i);
                1: begin
                    idx = 4'($urandom);
                    dbg_write(i, {6'd0, idx}, $urandom);
                    peek(i, {6'd0, idx}, mdl_mem[i][{6'd0, idx}], $sformatf("rand_dbg%0d", i));
                end
                default: begin
                    oob   = ($urandom_range(0, 7) == 0);
                    upper = oob ? 20'($urandom_range(1, 20'hFFFFF)) : 20'd0;
                    idx   = 4'($urandom);
                    a     = {upper, 6'd0, idx, 2'($urandom)};
                    d     = $urandom;
                    w     = 1'($urandom);
                    exp_out = (!w && in_range(a)) ? mdl_mem[i][a[11:2]] : 32'd0;
                    access(i, a, d, w, exp_out, !in_range(a));
                end
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0014, 32'h0,         1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{32'h0000_0014, 32'h12345678,  1'b1, 32'h0,        1'b0};
        vecs[2]  = '{32'h0000_0014, 32'h0,         1'b0, 32'h12345678, 1'b0};
        vecs[3]  = '{32'h0001_0000, 32'hA5A5A5A5,  1'b1, 32'h0,        1'b1};
        vecs[4]  = '{32'h0001_0000, 32'h0,         1'b0, 32'h0,        1'b1};
        vecs[5]  = '{32'h0000_0FFC, 32'hC0FFEE01,  1'b1, 32'h0,        1'b0};
        vecs[6]  = '{32'h0000_0FFC, 32'h0,         1'b0, 32'hC0FFEE01, 1'b0};
        vecs[7]  = '{32'h0000_1000, 32'h0,         1'b0, 32'h0,        1'b1};
        vecs[8]  = '{32'h0000_1000, 32'hBAD0BAD0,  1'b1, 32'h0,        1'b1};
        vecs[9]  = '{32'h0000_0000, 32'h0,         1'b0, 32'h11111111, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h0,         1'b0, 32'h0,        1'b1};

        for (int i = 0; i < 2; i++) begin
            addr_s[i] = 32'h14; din_s[i] = '0; en_s[i] = 1'b1; wr_s[i] = 1'b0;
            dbg_we_s[i] = 1'b0; dbg_addr_s[i] = '0; dbg_wdata_s[i] = '0;
            mdl_rd[i] = 0; mdl_wr[i] = 0;
        end

        // Reset held with a request pending: outputs must stay quiet.
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_stall%0d", i), stall_s[i], 0);
            chk($sformatf("rst_dout%0d", i), dout_s[i], 0);
            chk($sformatf("rst_oob%0d", i), oob_s[i], 0);
            check_counts(i);
        end
        step();
        rst = 1'b0;
        en_s[0] = 1'b0;
        en_s[1] = 1'b0;
        idle(0);

        // Directed vectors on the two-wait-state instance, back to back.
        dbg_write(0, 10'd5, 32'hDEADBEEF);
        dbg_write(0, 10'd0, 32'h11111111);
        for (int v = 0; v < 11; v++) begin
            access(0, vecs[v].addr, vecs[v].data, vecs[v].wr, vecs[v].exp_out, vecs[v].exp_oob);
        end
        peek(0, 10'd0, 32'h11111111, "oob_no_alias");
        peek(0, 10'd1023, 32'hC0FFEE01, "top_word");

        // Zero-latency instance.
        dbg_write(1, 10'd2, 32'h0BADF00D);
        access(1, 32'h8, 32'h0, 1'b0, 32'h0BADF00D, 1'b0);
        access(1, 32'h8, 32'hFEEDFACE, 1'b1, 32'h0, 1'b0);
        access(1, 32'h8, 32'h0, 1'b0, 32'hFEEDFACE, 1'b0);
        access(1, 32'h0010_0008, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b1);
        peek(1, 10'd2, 32'hFEEDFACE, "l0_oob_write_dropped");

        // Reset while a write is waiting.
        dbg_write(0, 10'd9, 32'h99999999);
        en_s[0] = 1'b1; addr_s[0] = 32'h24; din_s[0] = 32'h5555AAAA; wr_s[0] = 1'b1;
        @(negedge clk);
        chk("t5_stall_c0", stall_s[0], 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_stall_in_rst", stall_s[0], 0);
        step();
        rst = 1'b0;
        en_s[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mdl_rd[i] = 0;
            mdl_wr[i] = 0;
        end
        @(negedge clk);
        chk("t5_stall_after", stall_s[0], 0);
        chk("t5_dout_after", dout_s[0], 0);
        check_counts(0);
        check_counts(1);
        step();
        idle(0);
        idle(0);
        peek(0, 10'd9, 32'h99999999, "t5_mem_unchanged");
        access(0, 32'h24, 32'h0, 1'b0, 32'h99999999, 1'b0);

        // Debug write colliding with a completing CPU write to the same word.
        dbg_write(0, 10'd7, 32'h77777777);
        en_s[0] = 1'b1; addr_s[0] = 32'h1C; din_s[0] = 32'hC0DE0007; wr_s[0] = 1'b1;
        @(negedge clk);
        chk("t6_stall_c0", stall_s[0], 1);
        step();
        @(negedge clk);
        chk("t6_stall_c1", stall_s[0], 1);
        step();
        dbg_we_s[0] = 1'b1; dbg_addr_s[0] = 10'd7; dbg_wdata_s[0] = 32'hBADBAD00;
        @(negedge clk);
        chk("t6_stall_c2", stall_s[0], 0);
        step();
        dbg_we_s[0] = 1'b0;
        en_s[0] = 1'b0;
        mdl_mem[0][7] = 32'hC0DE0007;
        mdl_wr[0]++;
        peek(0, 10'd7, 32'hC0DE0007, "t6_cpu_wins");
        check_counts(0);

        rand_phase(0, 150);
        rand_phase(1, 150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
